pipeline_fetch: RTL and testbench
=================================

PIPELINE_FETCH -- requirements
Module: pipeline_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have port clk_i, input, 1: clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port imem_req_o, output, 1: instruction-memory request.
REQ-005 SHALL have port imem_addr_o, output, 32: request byte address, word aligned.
REQ-006 SHALL have port imem_gnt_i, input, 1: request accepted this cycle when imem_req_o=1.
REQ-007 SHALL have port imem_rvalid_i, input, 1: response valid, exactly one cycle after the accepting cycle.
REQ-008 SHALL have port imem_rdata_i, input, 32: response instruction word.
REQ-009 SHALL have port redirect_i, input, 1: branch/jump/trap redirect, single-cycle pulse.
REQ-010 SHALL have port redirect_pc_i, input, 32: redirect target.
REQ-011 SHALL have port stall_i, input, 1: decode not accepting this cycle.
REQ-012 SHALL have port instruction_o, output, 32: instruction to decode.
REQ-013 SHALL have port pc_o, output, 32: PC of instruction_o.
REQ-014 SHALL have port valid_o, output, 1: instruction_o/pc_o valid.
REQ-015 SHALL have port misalign_o, output, 1: misaligned redirect flag (see Configuration).

Function
REQ-016 SHALL hold a fetch PC, a 2-entry {pc,instr} FIFO, and a state machine with states RUN (none outstanding), WAIT (one outstanding), DISCARD (one outstanding, to be dropped).
REQ-017 SHALL allow at most one outstanding request; imem_req_o=1 only when FIFO count plus outstanding count < 2, no redirect this cycle, and state is RUN or an expected response arrives this cycle.
REQ-018 SHALL drive imem_addr_o = fetch PC and keep it stable while imem_req_o=1 and imem_gnt_i=0.
REQ-019 SHALL on req&gnt advance fetch PC by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0), and enter WAIT.
REQ-020 SHALL in WAIT, on imem_rvalid_i, write {request addr, imem_rdata_i} into the FIFO; entry visible on outputs the following cycle.
REQ-021 SHALL drive valid_o = FIFO non-empty; instruction_o/pc_o = FIFO head; both 0 when empty.
REQ-022 SHALL pop the head when valid_o=1 and stall_i=0; outputs stable while stall_i=1.
REQ-023 SHALL support simultaneous push and pop with count unchanged; a full FIFO never receives a push (guaranteed by REQ-017).
REQ-024 SHALL on redirect_i: flush FIFO (valid_o=0 next cycle), load fetch PC from redirect_pc_i, deassert imem_req_o that cycle, enter DISCARD if a request is outstanding, else RUN.
REQ-025 SHALL in DISCARD drop the arriving response, then behave as in WAIT for issuing; redirect coincident with imem_rvalid_i drops that response.
REQ-026 SHALL meet latency: redirect cycle N, req at N+1; if granted at N+1, rvalid N+2, valid_o=1 with pc_o=target at N+3.
REQ-027 SHALL, with gnt tied 1 and stall_i=0, deliver one instruction every cycle in steady state.

Reset
REQ-028 SHALL on rst_i asynchronously set fetch PC=RESET_PC, FIFO empty, state RUN, imem_req_o=0, valid_o=0, instruction_o=0, pc_o=0, misalign_o=0.
REQ-029 SHALL assert imem_req_o with imem_addr_o=RESET_PC in the first cycle after rst_i deasserts.
REQ-030 SHALL on reset mid-transaction discard the outstanding response; an imem_rvalid_i in the first cycle after reset is ignored.

Configuration
REQ-031 SHALL with macro FETCH_MISALIGN_CHK_EN defined: a redirect with redirect_pc_i[1:0]!=0 flushes as REQ-024, stops issuing requests, sets misalign_o=1 held until an aligned redirect or reset.
REQ-032 SHALL without FETCH_MISALIGN_CHK_EN: redirect target bits [1:0] forced to 0, misalign_o tied 0.

Verification
REQ-033 Reset release, gnt=1, rvalid one cycle later -> addresses 0,4,8 issued in consecutive cycles, valid_o from cycle 3 with pc_o 0,4,8.
REQ-034 stall_i=1 for 5 cycles with full FIFO -> imem_req_o=0, instruction_o/pc_o unchanged; release -> pops resume, no loss or duplication.
REQ-035 Redirect to 32'h0000_0100 while a request to 0x10 is outstanding -> 0x10 data dropped, next valid pc_o=0x100.
REQ-036 Fetch PC 32'hFFFF_FFFC granted -> next request address 32'h0000_0000.
REQ-037 gnt=0 for 3 cycles -> imem_addr_o held stable, one response accepted after grant.
REQ-038 FETCH_MISALIGN_CHK_EN defined, redirect to 32'h0000_0102 -> misalign_o=1, no requests; redirect to 0x200 clears it; undefined -> fetch proceeds from 0x100.

Source files
------------

// File: rtl/pipeline_fetch.sv
// pipeline_fetch: single-outstanding instruction fetch front end feeding
// decode through a 2-entry {pc,instr} buffer.
// Optional feature macro: FETCH_MISALIGN_CHK_EN. When defined, a redirect to
// a non-word-aligned target raises misalign_o and halts fetching until an
// aligned redirect. When undefined, target bits [1:0] are dropped.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_RUN     | no request outstanding
// ST_WAIT    | one request outstanding, its response goes to buffer
// ST_DISCARD | one request outstanding, its response is dropped
module pipeline_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic        misalign_o
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  logic [1:0]  state;
  logic [31:0] fetch_pc;
  logic [31:0] req_addr;

  logic [1:0]  count;
  logic [31:0] head_pc;
  logic [31:0] head_instr;
  logic [31:0] tail_pc;
  logic [31:0] tail_instr;

  logic        outstanding;
  logic        resp_hit;
  logic        pop;
  logic        push;
  logic        fire;
  logic [1:0]  occupancy;
  logic [31:0] redirect_target;
  logic        misalign_q;

  assign outstanding = (state != ST_RUN);
  assign resp_hit    = outstanding & imem_rvalid_i;
  assign valid_o     = (count != 2'd0);
  assign pop         = valid_o & ~stall_i;
  assign push        = resp_hit & (state == ST_WAIT) & ~redirect_i;

  // Occupancy counts the slot freed by this cycle's pop, otherwise the
  // buffer could not sustain one instruction per cycle with gnt tied high.
  assign occupancy   = count - {1'b0, pop} + {1'b0, outstanding};

  // rst_i gates the request so it is low for the whole reset interval and
  // rises in the very first cycle after release.
  assign imem_req_o  = ~rst_i & ~misalign_q & ~redirect_i &
                       (occupancy < 2'd2) &
                       ((state == ST_RUN) | resp_hit);
  assign imem_addr_o = fetch_pc;
  assign fire        = imem_req_o & imem_gnt_i;

  assign instruction_o = valid_o ? head_instr : 32'd0;
  assign pc_o          = valid_o ? head_pc    : 32'd0;

  // The fetch PC is always kept word aligned.
  assign redirect_target = {redirect_pc_i[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHK_EN
  // Misalign flag is re-evaluated on every redirect and otherwise sticky.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      misalign_q <= 1'b0;
    end else if (redirect_i) begin
      misalign_q <= (redirect_pc_i[1:0] != 2'b00);
    end
  end
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^redirect_pc_i[1:0];
  assign misalign_q    = 1'b0;
`endif

  assign misalign_o = misalign_q;

  // Fetch PC, outstanding-request bookkeeping and state transitions.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_RUN;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else if (redirect_i) begin
      fetch_pc <= redirect_target;
      // A response arriving in the redirect cycle is simply not captured.
      state    <= (outstanding && !imem_rvalid_i) ? ST_DISCARD : ST_RUN;
    end else begin
      if (fire) begin
        fetch_pc <= fetch_pc + 32'd4;
        req_addr <= fetch_pc;
      end
      case (state)
        ST_RUN: begin
          if (fire) state <= ST_WAIT;
        end
        ST_WAIT, ST_DISCARD: begin
          if (imem_rvalid_i) state <= fire ? ST_WAIT : ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Two-entry buffer toward decode; head is always the entry on the outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count      <= 2'd0;
      head_pc    <= 32'd0;
      head_instr <= 32'd0;
      tail_pc    <= 32'd0;
      tail_instr <= 32'd0;
    end else if (redirect_i) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_pc    <= req_addr;
            head_instr <= imem_rdata_i;
          end else begin
            tail_pc    <= req_addr;
            tail_instr <= imem_rdata_i;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_pc    <= tail_pc;
          head_instr <= tail_instr;
          count      <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_pc    <= req_addr;
            head_instr <= imem_rdata_i;
          end else begin
            head_pc    <= tail_pc;
            head_instr <= tail_instr;
            tail_pc    <= req_addr;
            tail_instr <= imem_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_fetch.sv
// Testbench for pipeline_fetch: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the fetch rules.
module tb_pipeline_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        misalign_o;

  int n_checks = 0;
  int n_pass   = 0;

  pipeline_fetch dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .instruction_o (instruction_o),
    .pc_o          (pc_o),
    .valid_o       (valid_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: buffer contents as a queue, one optional outstanding
  // request with a drop flag, the next fetch address and the misalign flag.
  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_out_addr;
  bit          m_out;
  bit          m_drop;
  bit          m_mis;
  bit          mem_next;

  bit          e_req;
  bit          e_valid;
  bit          e_pop;
  logic [31:0] e_addr;
  logic [31:0] e_pc;
  logic [31:0] e_instr;

  function automatic void model_reset();
    m_q.delete();
    m_pc       = 32'h0000_0000;
    m_out_addr = 32'h0;
    m_out      = 0;
    m_drop     = 0;
    m_mis      = 0;
    mem_next   = 0;
  endfunction

  function automatic void model_comb();
    int occ;
    e_valid = (m_q.size() != 0);
    e_pc    = e_valid ? m_q[0][63:32] : 32'h0;
    e_instr = e_valid ? m_q[0][31:0]  : 32'h0;
    e_pop   = e_valid && !stall_i;
    occ     = m_q.size() - (e_pop ? 1 : 0) + (m_out ? 1 : 0);
    e_req   = !rst_i && !m_mis && !redirect_i && (occ < 2) &&
              (!m_out || imem_rvalid_i);
    e_addr  = m_pc;
  endfunction

  function automatic void model_seq();
    bit granted;
    bit resp;
    logic [31:0] t;
    granted = e_req && imem_gnt_i;
    resp    = m_out && imem_rvalid_i;
    if (redirect_i) begin
      t = redirect_pc_i;
      m_q.delete();
`ifdef FETCH_MISALIGN_CHK_EN
      m_mis = (t[1:0] != 2'b00);
`endif
      m_pc   = {t[31:2], 2'b00};
      m_out  = m_out && !resp;
      m_drop = m_out;
    end else begin
      if (e_pop) void'(m_q.pop_front());
      if (resp) begin
        if (!m_drop) m_q.push_back({m_out_addr, imem_rdata_i});
        m_out  = 0;
        m_drop = 0;
      end
      if (granted) begin
        m_out      = 1;
        m_drop     = 0;
        m_out_addr = m_pc;
        m_pc       = m_pc + 32'd4;
      end
    end
    mem_next = granted;
  endfunction

  task automatic settle();
    @(negedge clk_i);
    model_comb();
  endtask

  task automatic advance();
    @(posedge clk_i);
    model_seq();
    #1;
    imem_rvalid_i = mem_next;
    imem_rdata_i  = $urandom();
    redirect_i    = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (imem_req_o !== 1'b0 || valid_o !== 1'b0 || pc_o !== 32'h0 ||
        instruction_o !== 32'h0 || misalign_o !== 1'b0)
      $display("FAIL reset_outputs: req=%b valid=%b pc=%h instr=%h mis=%b, want all 0",
               imem_req_o, valid_o, pc_o, instruction_o, misalign_o);
    else n_pass++;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hBAD0_BAD0;
  endtask

  task automatic test_startup();
    imem_gnt_i = 1'b1;
    stall_i    = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      settle();
      if (k <= 3) begin
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'(4 * (k - 1)))
          $display("FAIL startup_req c%0d: req=%b addr=%h, want 1 %h",
                   k, imem_req_o, imem_addr_o, 32'(4 * (k - 1)));
        else n_pass++;
      end
      n_checks++;
      if (k < 3) begin
        if (valid_o !== 1'b0)
          $display("FAIL startup_valid c%0d: valid=%b, want 0", k, valid_o);
        else n_pass++;
      end else begin
        if (valid_o !== 1'b1 || pc_o !== 32'(4 * (k - 3)) || instruction_o !== e_instr)
          $display("FAIL startup_out c%0d: valid=%b pc=%h instr=%h, want 1 %h %h",
                   k, valid_o, pc_o, instruction_o, 32'(4 * (k - 3)), e_instr);
        else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_stall();
    bit full;
    logic [31:0] held_pc, held_instr, exp_next;
    full = 0;
    stall_i = 1'b1;
    for (int i = 0; i < 10 && !full; i++) begin
      settle();
      if (m_q.size() == 2) full = 1;
      else advance();
    end
    n_checks++;
    if (!full || valid_o !== 1'b1)
      $display("FAIL stall_fill: full=%0d valid=%b, want buffer full", full, valid_o);
    else n_pass++;
    held_pc    = e_pc;
    held_instr = e_instr;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) settle();
      n_checks++;
      if (imem_req_o !== 1'b0 || pc_o !== held_pc || instruction_o !== held_instr)
        $display("FAIL stall_hold c%0d: req=%b pc=%h instr=%h, want 0 %h %h",
                 i, imem_req_o, pc_o, instruction_o, held_pc, held_instr);
      else n_pass++;
      advance();
    end
    stall_i  = 1'b0;
    exp_next = held_pc;
    for (int i = 0; i < 8; i++) begin
      settle();
      n_checks++;
      if (valid_o !== 1'b1 || pc_o !== exp_next || instruction_o !== e_instr)
        $display("FAIL stall_release c%0d: valid=%b pc=%h instr=%h, want 1 %h %h",
                 i, valid_o, pc_o, instruction_o, exp_next, e_instr);
      else n_pass++;
      exp_next = exp_next + 32'd4;
      advance();
    end
  endtask

  task automatic test_redirect();
    imem_gnt_i    = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0010;
    settle();
    n_checks++;
    if (imem_req_o !== 1'b0)
      $display("FAIL redir_req_low: req=%b, want 0", imem_req_o);
    else n_pass++;
    advance();
    settle();
    n_checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10 || valid_o !== 1'b0)
      $display("FAIL redir_first_req: req=%b addr=%h valid=%b, want 1 00000010 0",
               imem_req_o, imem_addr_o, valid_o);
    else n_pass++;
    advance();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0100;
    settle();
    n_checks++;
    if (imem_req_o !== 1'b0)
      $display("FAIL redir2_req_low: req=%b, want 0", imem_req_o);
    else n_pass++;
    advance();
    for (int k = 1; k <= 3; k++) begin
      settle();
      n_checks++;
      if (k == 1) begin
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || valid_o !== 1'b0)
          $display("FAIL redir_latency_req: req=%b addr=%h valid=%b, want 1 00000100 0",
                   imem_req_o, imem_addr_o, valid_o);
        else n_pass++;
      end else if (k == 2) begin
        if (valid_o !== 1'b0)
          $display("FAIL redir_drop: valid=%b pc=%h, want valid 0", valid_o, pc_o);
        else n_pass++;
      end else begin
        if (valid_o !== 1'b1 || pc_o !== 32'h100 || instruction_o !== e_instr)
          $display("FAIL redir_target_out: valid=%b pc=%h instr=%h, want 1 00000100 %h",
                   valid_o, pc_o, instruction_o, e_instr);
        else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] a;
    imem_gnt_i    = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFF8;
    settle();
    advance();
    a = 32'hFFFF_FFF8;
    for (int k = 1; k <= 5; k++) begin
      settle();
      if (k <= 3) begin
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== a)
          $display("FAIL wrap_addr c%0d: req=%b addr=%h, want 1 %h", k, imem_req_o, imem_addr_o, a);
        else n_pass++;
        a = a + 32'd4;
      end
      if (k >= 3) begin
        n_checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'(32'hFFFF_FFF8 + 32'(4 * (k - 3))))
          $display("FAIL wrap_pc c%0d: valid=%b pc=%h, want 1 %h",
                   k, valid_o, pc_o, 32'(32'hFFFF_FFF8 + 32'(4 * (k - 3))));
        else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_gnt_hold();
    stall_i       = 1'b0;
    imem_gnt_i    = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0040;
    settle();
    advance();
    for (int k = 1; k <= 7; k++) begin
      if (k == 4) imem_gnt_i = 1'b1;
      if (k == 5) imem_gnt_i = 1'b0;
      settle();
      n_checks++;
      if (k <= 4) begin
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40 || valid_o !== 1'b0)
          $display("FAIL gnt_hold c%0d: req=%b addr=%h valid=%b, want 1 00000040 0",
                   k, imem_req_o, imem_addr_o, valid_o);
        else n_pass++;
      end else if (k == 5) begin
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h44 || valid_o !== 1'b0)
          $display("FAIL gnt_next c%0d: req=%b addr=%h valid=%b, want 1 00000044 0",
                   k, imem_req_o, imem_addr_o, valid_o);
        else n_pass++;
      end else if (k == 6) begin
        if (valid_o !== 1'b1 || pc_o !== 32'h40 || instruction_o !== e_instr)
          $display("FAIL gnt_resp: valid=%b pc=%h instr=%h, want 1 00000040 %h",
                   valid_o, pc_o, instruction_o, e_instr);
        else n_pass++;
      end else begin
        if (valid_o !== 1'b0)
          $display("FAIL gnt_single: valid=%b pc=%h, want valid 0", valid_o, pc_o);
        else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_misalign();
    imem_gnt_i    = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0102;
    settle();
    advance();
`ifdef FETCH_MISALIGN_CHK_EN
    for (int k = 1; k <= 4; k++) begin
      settle();
      n_checks++;
      if (misalign_o !== 1'b1 || imem_req_o !== 1'b0 || valid_o !== 1'b0)
        $display("FAIL misalign_set c%0d: mis=%b req=%b valid=%b, want 1 0 0",
                 k, misalign_o, imem_req_o, valid_o);
      else n_pass++;
      advance();
    end
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    settle();
    advance();
    settle();
    n_checks++;
    if (misalign_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h200)
      $display("FAIL misalign_clear: mis=%b req=%b addr=%h, want 0 1 00000200",
               misalign_o, imem_req_o, imem_addr_o);
    else n_pass++;
    advance();
`else
    for (int k = 1; k <= 3; k++) begin
      settle();
      n_checks++;
      if (k == 1) begin
        if (misalign_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100)
          $display("FAIL align_force: mis=%b req=%b addr=%h, want 0 1 00000100",
                   misalign_o, imem_req_o, imem_addr_o);
        else n_pass++;
      end else if (k == 3) begin
        if (valid_o !== 1'b1 || pc_o !== 32'h100 || misalign_o !== 1'b0)
          $display("FAIL align_out: valid=%b pc=%h mis=%b, want 1 00000100 0",
                   valid_o, pc_o, misalign_o);
        else n_pass++;
      end else begin
        if (misalign_o !== 1'b0)
          $display("FAIL align_mis: mis=%b, want 0", misalign_o);
        else n_pass++;
      end
      advance();
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] t;
    for (int c = 0; c < 400; c++) begin
      imem_gnt_i = ($urandom_range(0, 9) < 7);
      stall_i    = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 99) < 6) begin
        t = $urandom();
        if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
        redirect_i    = 1'b1;
        redirect_pc_i = t;
      end
      settle();
      n_checks++;
      if (imem_req_o !== e_req || (e_req && imem_addr_o !== e_addr))
        $display("FAIL rand_req c%0d: req=%b addr=%h, want %b %h",
                 c, imem_req_o, imem_addr_o, e_req, e_addr);
      else n_pass++;
      n_checks++;
      if (valid_o !== e_valid || pc_o !== e_pc || instruction_o !== e_instr)
        $display("FAIL rand_out c%0d: valid=%b pc=%h instr=%h, want %b %h %h",
                 c, valid_o, pc_o, instruction_o, e_valid, e_pc, e_instr);
      else n_pass++;
      n_checks++;
      if (misalign_o !== m_mis)
        $display("FAIL rand_mis c%0d: mis=%b, want %b", c, misalign_o, m_mis);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    got = 0;
    imem_gnt_i    = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0300;
    settle();
    advance();
    for (int i = 0; i < 6 && !got; i++) begin
      settle();
      got = e_req;
      advance();
    end
    n_checks++;
    if (!got || imem_rvalid_i !== 1'b1)
      $display("FAIL rstmid_setup: granted=%0d, want an outstanding request", got);
    else n_pass++;
    rst_i = 1'b1;
    #2;
    n_checks++;
    if (imem_req_o !== 1'b0 || valid_o !== 1'b0 || pc_o !== 32'h0 ||
        instruction_o !== 32'h0 || misalign_o !== 1'b0)
      $display("FAIL rstmid_async: req=%b valid=%b pc=%h instr=%h mis=%b, want all 0",
               imem_req_o, valid_o, pc_o, instruction_o, misalign_o);
    else n_pass++;
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i         = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    settle();
    n_checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || valid_o !== 1'b0)
      $display("FAIL rstmid_release: req=%b addr=%h valid=%b, want 1 00000000 0",
               imem_req_o, imem_addr_o, valid_o);
    else n_pass++;
    advance();
    for (int k = 2; k <= 5; k++) begin
      settle();
      n_checks++;
      if (valid_o !== e_valid || pc_o !== e_pc || instruction_o !== e_instr ||
          (k >= 3 && pc_o !== 32'(4 * (k - 3))))
        $display("FAIL rstmid_out c%0d: valid=%b pc=%h instr=%h, want %b %h %h",
                 k, valid_o, pc_o, instruction_o, e_valid, e_pc, e_instr);
      else n_pass++;
      advance();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_i         = 1'b1;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    stall_i       = 1'b0;
    model_reset();
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_wrap();
    test_gnt_hold();
    test_misalign();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
